// File: rtl/uart_pkg.sv
// Shared UART definitions: bus register map, receiver state encoding and
// the status word layout used by the RX controller.
package uart_pkg;

  localparam logic [4:0] REG_STATUS = 5'd0;
  localparam logic [4:0] REG_DVSR   = 5'd1;
  localparam logic [4:0] REG_POP    = 5'd2;
  localparam logic [4:0] REG_CLR    = 5'd3;

  localparam int DVSR_W = 11;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  function automatic logic [31:0] status_word(input logic ovr, input logic full,
                                              input logic empty, input logic [7:0] head);
    return {21'b0, ovr, full, empty, head};
  endfunction

endpackage

// File: rtl/baud_gen.sv
// Free-running oversampling tick generator: one-clk tick every dvsr+1 clks,
// restartable from zero by clr.
module baud_gen
  import uart_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [DVSR_W-1:0] dvsr,
  input  logic              clr,
  output logic              tick
);

  logic [DVSR_W-1:0] cnt_reg, cnt_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_reg <= '0;
    else       cnt_reg <= cnt_next;
  end

  always_comb begin
    cnt_next = (cnt_reg == dvsr) ? '0 : cnt_reg + DVSR_W'(1);
    if (clr) cnt_next = '0;
  end

  assign tick = (cnt_reg == dvsr);

endmodule

// File: rtl/uart_rx.sv
// Oversampling serial receiver: 16 ticks per data bit, samples mid-bit,
// LSB first, strobes rx_done_tick once per frame mid-way through the stop bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  output logic            rx_done_tick,
  output logic [DBIT-1:0] dout
);

  localparam int S_W = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
  localparam int N_W = (DBIT > 1) ? $clog2(DBIT) : 1;

  rx_state_t        state_reg, state_next;
  logic [S_W-1:0]   s_reg, s_next;
  logic [N_W-1:0]   n_reg, n_next;
  logic [DBIT-1:0]  b_reg, b_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= RX_IDLE;
      s_reg     <= '0;
      n_reg     <= '0;
      b_reg     <= '0;
    end else begin
      state_reg <= state_next;
      s_reg     <= s_next;
      n_reg     <= n_next;
      b_reg     <= b_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    n_next     = n_reg;
    b_next     = b_reg;
    case (state_reg)
      RX_IDLE: begin
        if (!rx) begin
          state_next = RX_START;
          s_next     = '0;
        end
      end
      RX_START: begin
        // eight ticks lands in the middle of the start bit
        if (s_tick) begin
          if (s_reg == S_W'(7)) begin
            state_next = RX_DATA;
            s_next     = '0;
            n_next     = '0;
          end else begin
            s_next = s_reg + S_W'(1);
          end
        end
      end
      RX_DATA: begin
        if (s_tick) begin
          if (s_reg == S_W'(15)) begin
            s_next = '0;
            b_next = {rx, b_reg[DBIT-1:1]};
            if (n_reg == N_W'(DBIT - 1)) state_next = RX_STOP;
            else                         n_next     = n_reg + N_W'(1);
          end else begin
            s_next = s_reg + S_W'(1);
          end
        end
      end
      RX_STOP: begin
        if (s_tick) begin
          if (s_reg == S_W'(SB_TICK - 1)) state_next = RX_IDLE;
          else                            s_next     = s_reg + S_W'(1);
        end
      end
      default: state_next = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_done_tick = (state_reg == RX_STOP) && s_tick && (s_reg == S_W'(SB_TICK - 1));
  end

  assign dout = b_reg;

endmodule

// File: rtl/uart_rx_ctrl.sv
// Bus-attached UART receiver: synchronizer, programmable baud tick, receiver
// and a small first-word-fall-through FIFO with sticky overrun flag.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DBIT     = 8,
  parameter int SB_TICK  = 16,
  parameter int FIFO_W   = 2,
  parameter int DVSR_RST = 325
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [4:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  input  logic        rx,
  output logic        rx_irq
);

  localparam int DEPTH = 2 ** FIFO_W;

  logic              rx_meta_reg, rx_sync_reg;
  logic [DVSR_W-1:0] dvsr_reg;
  logic              s_tick, rx_done_tick;
  logic [DBIT-1:0]   rx_dout;

  logic              wr_dvsr, pop_req, clr_req;
  logic              do_push, do_pop, overrun;

  logic [DBIT-1:0]   fifo_mem [DEPTH];
  logic [FIFO_W-1:0] wr_ptr_reg, wr_ptr_next, rd_ptr_reg, rd_ptr_next;
  logic [FIFO_W-1:0] wr_ptr_succ, rd_ptr_succ;
  logic              full_reg, full_next, empty_reg, empty_next;
  logic              ovr_reg, ovr_next;
  logic [7:0]        head_byte;

  // read is accepted for bus completeness; reads never change state
  logic unused_read;
  assign unused_read = read;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
    end else begin
      rx_meta_reg <= rx;
      rx_sync_reg <= rx_meta_reg;
    end
  end

  assign wr_dvsr = cs && write && (addr == REG_DVSR);
  assign pop_req = cs && write && (addr == REG_POP);
  assign clr_req = cs && write && (addr == REG_CLR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        dvsr_reg <= DVSR_W'(DVSR_RST);
    else if (wr_dvsr) dvsr_reg <= wr_data[DVSR_W-1:0];
  end

  baud_gen u_baud_gen (
    .clk   (clk),
    .reset (reset),
    .dvsr  (dvsr_reg),
    .clr   (wr_dvsr),
    .tick  (s_tick)
  );

  uart_rx #(
    .DBIT    (DBIT),
    .SB_TICK (SB_TICK)
  ) u_uart_rx (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx_sync_reg),
    .s_tick       (s_tick),
    .rx_done_tick (rx_done_tick),
    .dout         (rx_dout)
  );

  // a pop frees a slot in the same edge, so push+pop while full keeps both
  assign do_pop  = pop_req && !empty_reg;
  assign do_push = rx_done_tick && (!full_reg || do_pop);
  assign overrun = rx_done_tick && full_reg && !do_pop;

  assign wr_ptr_succ = wr_ptr_reg + FIFO_W'(1);
  assign rd_ptr_succ = rd_ptr_reg + FIFO_W'(1);

  always_ff @(posedge clk) begin
    if (do_push) fifo_mem[wr_ptr_reg] <= rx_dout;
  end

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    full_next   = full_reg;
    empty_next  = empty_reg;
    case ({do_push, do_pop})
      2'b10: begin
        wr_ptr_next = wr_ptr_succ;
        empty_next  = 1'b0;
        full_next   = (wr_ptr_succ == rd_ptr_reg);
      end
      2'b01: begin
        rd_ptr_next = rd_ptr_succ;
        full_next   = 1'b0;
        empty_next  = (rd_ptr_succ == wr_ptr_reg);
      end
      2'b11: begin
        wr_ptr_next = wr_ptr_succ;
        rd_ptr_next = rd_ptr_succ;
      end
      default: ;
    endcase
    ovr_next = ovr_reg;
    if (clr_req) ovr_next = 1'b0;
    if (overrun) ovr_next = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
      ovr_reg    <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      full_reg   <= full_next;
      empty_reg  <= empty_next;
      ovr_reg    <= ovr_next;
    end
  end

  always_comb begin
    head_byte = empty_reg ? 8'h00 : 8'(fifo_mem[rd_ptr_reg]);
    case (addr)
      REG_STATUS: rd_data = status_word(ovr_reg, full_reg, empty_reg, head_byte);
      REG_DVSR:   rd_data = {21'b0, dvsr_reg};
      default:    rd_data = 32'h0;
    endcase
  end

  assign rx_irq = !empty_reg || ovr_reg;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: serial frames driven on rx, checked against a
// queue-based model of the FIFO, overrun flag and divisor register.
module tb_uart_rx_ctrl;
  import uart_pkg::*;

  localparam int DEPTH    = 4;
  localparam int DVSR_DEF = 325;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs, read, write;
  logic [4:0]  addr;
  logic [31:0] wr_data, rd_data;
  logic        rx, rx_irq;

  always #5 clk = ~clk;

  uart_rx_ctrl #(
    .DBIT(8), .SB_TICK(16), .FIFO_W(2), .DVSR_RST(DVSR_DEF)
  ) dut (
    .clk(clk), .reset(reset), .cs(cs), .read(read), .write(write),
    .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .rx(rx), .rx_irq(rx_irq)
  );

  int checks = 0;
  int errors = 0;

  // reference model
  byte unsigned q[$];
  bit           m_ovr;
  int           m_dvsr;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h exp 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s 0x%08h", tag, got);
    end
  endtask

  function automatic logic [31:0] exp_status();
    logic [7:0] h;
    h = (q.size() > 0) ? q[0] : 8'h00;
    return {21'b0, m_ovr, (q.size() == DEPTH), (q.size() == 0), h};
  endfunction

  function automatic void m_push(input byte unsigned b);
    if (q.size() < DEPTH) q.push_back(b);
    else                  m_ovr = 1'b1;
  endfunction

  function automatic void m_pop();
    if (q.size() > 0) void'(q.pop_front());
  endfunction

  function automatic void m_reset();
    q.delete();
    m_ovr  = 1'b0;
    m_dvsr = DVSR_DEF;
  endfunction

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
    @(negedge clk);
    cs = 1'b0; write = 1'b0; wr_data = '0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a; read = 1'b1;
    #1 d = rd_data;
    read = 1'b0;
  endtask

  task automatic check_status(input string tag);
    logic [31:0] d;
    bus_read(REG_STATUS, d);
    check_val(tag, d, exp_status());
    check_val({tag, "_irq"}, {31'b0, rx_irq}, {31'b0, (q.size() > 0) || m_ovr});
  endtask

  task automatic check_dvsr(input string tag);
    logic [31:0] d;
    bus_read(REG_DVSR, d);
    check_val(tag, d, 32'(m_dvsr));
  endtask

  task automatic set_dvsr(input int v);
    bus_write(REG_DVSR, 32'(v));
    m_dvsr = v;
  endtask

  task automatic pop_and_check(input string tag);
    bus_write(REG_POP, 32'h0);
    m_pop();
    check_status(tag);
  endtask

  // frame = start(0), 8 data bits LSB first, stop(1)
  task automatic send_byte(input byte unsigned b);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = frame[i];
      repeat (16 * (m_dvsr + 1)) @(negedge clk);
    end
  endtask

  task automatic recv_byte(input byte unsigned b);
    send_byte(b);
    m_push(b);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [31:0] d;
    logic [9:0]  frame;
    bit          found;

    cs = 1'b0; read = 1'b0; write = 1'b0; addr = '0; wr_data = '0; rx = 1'b1;
    reset = 1'b1;
    m_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // reset state
    check_status("rst_status");
    check_dvsr("rst_dvsr");
    bus_read(5'd7, d);
    check_val("unmapped_addr", d, 32'h0);

    // single frame at 64 clk/bit
    set_dvsr(3);
    check_dvsr("dvsr_write");
    recv_byte(8'hA5);
    check_status("a5_head");
    pop_and_check("a5_popped");

    // cs low write is ignored
    @(negedge clk);
    cs = 1'b0; write = 1'b1; addr = REG_DVSR; wr_data = 32'd7;
    @(negedge clk);
    write = 1'b0;
    check_dvsr("cs_low_ignored");

    // pop while empty changes nothing; following byte lands normally
    pop_and_check("pop_empty");
    recv_byte(8'h77);
    check_status("after_empty_pop");
    pop_and_check("pop_77");

    // overrun: five frames into a four-deep FIFO
    for (int i = 1; i <= 5; i++) recv_byte(8'(i));
    check_status("ovr_full");
    for (int i = 1; i <= 4; i++) pop_and_check($sformatf("ovr_pop%0d", i));
    bus_write(REG_CLR, 32'h0);
    m_ovr = 1'b0;
    check_status("ovr_cleared");

    // pop exactly in the push cycle while full
    for (int i = 1; i <= 4; i++) recv_byte(8'(i));
    check_status("full_again");
    found = 1'b0;
    fork
      send_byte(8'h05);
      begin
        for (int n = 0; n < 4000 && !found; n++) begin
          @(negedge clk);
          if (dut.rx_done_tick === 1'b1) begin
            found = 1'b1;
            cs = 1'b1; write = 1'b1; addr = REG_POP;
            @(negedge clk);
            cs = 1'b0; write = 1'b0;
          end
        end
      end
    join
    check_val("done_tick_seen", {31'b0, found}, 32'h1);
    m_pop();
    m_push(8'h05);
    repeat (2) @(negedge clk);
    check_status("simul_push_pop");
    for (int i = 2; i <= 5; i++) pop_and_check($sformatf("simul_pop%0d", i));

    // reset in the middle of data bit 4
    frame = {1'b1, 8'h5A, 1'b0};
    for (int i = 0; i < 6; i++) begin
      rx = frame[i];
      repeat ((i == 5) ? 8 * (m_dvsr + 1) : 16 * (m_dvsr + 1)) @(negedge clk);
    end
    reset = 1'b1;
    rx = 1'b1;
    m_reset();
    repeat (4) @(negedge clk);
    reset = 1'b0;
    check_status("midframe_rst");
    check_dvsr("midframe_rst_dvsr");
    set_dvsr(3);
    repeat (400) @(negedge clk);
    check_status("midframe_no_push");
    recv_byte(8'h3C);
    check_status("after_rst_3c");
    pop_and_check("pop_3c");

    // randomized frames, divisors, pops and clears
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        set_dvsr(int'($urandom_range(0, 3)));
        check_dvsr($sformatf("rnd%0d_dvsr", it));
      end
      recv_byte(8'($urandom));
      check_status($sformatf("rnd%0d_rx", it));
      for (int p = $urandom_range(0, 2); p > 0; p--)
        pop_and_check($sformatf("rnd%0d_pop", it));
      if ($urandom_range(0, 4) == 0) begin
        bus_write(REG_CLR, 32'h0);
        m_ovr = 1'b0;
        check_status($sformatf("rnd%0d_clr", it));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
